// File: rtl/load_align_unit.sv
// load_align_unit: handshaked RISC-V load unit, one load in flight at a time.
// Define LOAD_MISALIGN_SPLIT_EN to split boundary-crossing loads into two reads.
module load_align_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [XLEN-1:0]  i_req_addr,
  input  logic [2:0]       i_req_funct3,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_mem_req,
  output logic [XLEN-1:0]  o_mem_addr,
  input  logic             i_mem_ack,
  input  logic [XLEN-1:0]  i_mem_rdata,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [XLEN-1:0]  o_rsp_data,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic             o_rsp_err
);

  localparam int NB = XLEN / 8;
  localparam int K  = $clog2(NB);

`ifdef LOAD_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_e;
`else
  typedef enum logic [1:0] {IDLE, RD0, RESP} state_e;
`endif

  state_e           state_q;
  logic [K-1:0]     off_q;
  logic [2:0]       f3_q;
  logic             mem_req_q;
  logic [XLEN-1:0]  mem_addr_q;
  logic             rsp_valid_q;
  logic [XLEN-1:0]  rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

  function automatic logic legal(input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    unique case (f3)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101: ok = 1'b1;
      3'b011, 3'b110: ok = (XLEN == 64);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [XLEN-1:0] extend(
    input logic [XLEN-1:0] v,
    input logic [2:0]      f3
  );
    logic [XLEN-1:0] r;
    r = v;
    unique case (f3)
      3'b000:  r = XLEN'($signed(v[7:0]));
      3'b001:  r = XLEN'($signed(v[15:0]));
      3'b010:  r = XLEN'($signed(v[31:0]));
      3'b100:  r = XLEN'(v[7:0]);
      3'b101:  r = XLEN'(v[15:0]);
      3'b110:  r = XLEN'(v[31:0]);
      default: r = v;
    endcase
    return r;
  endfunction

  logic [K-1:0]    req_off;
  logic            req_bad;
  logic [XLEN-1:0] req_aligned;
  logic [XLEN-1:0] lo_sel;
  logic [XLEN-1:0] raw;
  logic [K+2:0]    shamt;

  assign req_off     = i_req_addr[K-1:0];
  assign req_aligned = i_req_addr & ~XLEN'(NB - 1);
  assign shamt       = {off_q, 3'b000};

`ifdef LOAD_MISALIGN_SPLIT_EN
  logic [XLEN-1:0] beat0_q;
  logic [3:0]      cur_size;
  logic            cross;

  assign req_bad  = !legal(i_req_funct3);
  assign cur_size = size_of(f3_q);
  assign cross    = (5'(off_q) + 5'(cur_size)) > 5'(NB);
  // Low bytes of a split load come from the first beat.
  assign lo_sel   = (state_q == RD1) ? beat0_q : i_mem_rdata;
`else
  logic [3:0] req_size;

  assign req_size = size_of(i_req_funct3);
  assign req_bad  = !legal(i_req_funct3) ||
                    ((4'(req_off) & (req_size - 4'd1)) != 4'd0);
  assign lo_sel   = i_mem_rdata;
`endif

  assign raw = XLEN'({i_mem_rdata, lo_sel} >> shamt);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      off_q       <= '0;
      f3_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      beat0_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            off_q      <= req_off;
            f3_q       <= i_req_funct3;
            rsp_tag_q  <= i_req_tag;
            rsp_data_q <= '0;
            rsp_err_q  <= req_bad;
            if (req_bad) begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= req_aligned;
              state_q    <= RD0;
            end
          end
        end
        RD0: begin
          if (i_mem_ack) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
            if (cross) begin
              beat0_q    <= i_mem_rdata;
              mem_addr_q <= mem_addr_q + XLEN'(NB);
              state_q    <= RD1;
            end else
`endif
            begin
              mem_req_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= extend(raw, f3_q);
              state_q     <= RESP;
            end
          end
        end
`ifdef LOAD_MISALIGN_SPLIT_EN
        RD1: begin
          if (i_mem_ack) begin
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= extend(raw, f3_q);
            state_q     <= RESP;
          end
        end
`endif
        RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_mem_req   = mem_req_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_tag   = rsp_tag_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: XLEN=32 and XLEN=64 instances checked
// against a byte-level load model over a shared sparse memory.
`timescale 1ns/1ps
module tb_load_align_unit;

`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int total = 0;
  int bad = 0;

  logic        req_valid [2];
  logic [63:0] req_addr  [2];
  logic [2:0]  req_f3    [2];
  logic [4:0]  req_tag   [2];
  logic        mem_ack   [2];
  logic [63:0] mem_rdata [2];
  logic        rsp_ready [2];

  logic        rdy0, mreq0, rv0, err0;
  logic [31:0] maddr0, rdat0;
  logic [4:0]  tag0;
  logic        rdy1, mreq1, rv1, err1;
  logic [63:0] maddr1, rdat1;
  logic [4:0]  tag1;

  load_align_unit #(.XLEN(32), .TAG_W(5)) u32 (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid[0]), .o_req_ready(rdy0),
    .i_req_addr(req_addr[0][31:0]), .i_req_funct3(req_f3[0]),
    .i_req_tag(req_tag[0]),
    .o_mem_req(mreq0), .o_mem_addr(maddr0),
    .i_mem_ack(mem_ack[0]), .i_mem_rdata(mem_rdata[0][31:0]),
    .o_rsp_valid(rv0), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_data(rdat0), .o_rsp_tag(tag0), .o_rsp_err(err0)
  );

  load_align_unit #(.XLEN(64), .TAG_W(5)) u64 (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid[1]), .o_req_ready(rdy1),
    .i_req_addr(req_addr[1]), .i_req_funct3(req_f3[1]),
    .i_req_tag(req_tag[1]),
    .o_mem_req(mreq1), .o_mem_addr(maddr1),
    .i_mem_ack(mem_ack[1]), .i_mem_rdata(mem_rdata[1]),
    .o_rsp_valid(rv1), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_data(rdat1), .o_rsp_tag(tag1), .o_rsp_err(err1)
  );

  function automatic logic g_rdy(input int s);
    return s != 0 ? rdy1 : rdy0;
  endfunction
  function automatic logic g_mreq(input int s);
    return s != 0 ? mreq1 : mreq0;
  endfunction
  function automatic logic g_rv(input int s);
    return s != 0 ? rv1 : rv0;
  endfunction
  function automatic logic g_err(input int s);
    return s != 0 ? err1 : err0;
  endfunction
  function automatic logic [4:0] g_tag(input int s);
    return s != 0 ? tag1 : tag0;
  endfunction
  function automatic logic [63:0] g_maddr(input int s);
    return s != 0 ? maddr1 : {32'd0, maddr0};
  endfunction
  function automatic logic [63:0] g_rdata(input int s);
    return s != 0 ? rdat1 : {32'd0, rdat0};
  endfunction

  // Sparse byte memory; unwritten bytes follow a fixed address hash.
  logic [7:0] mem [logic [63:0]];

  function automatic logic [7:0] mbyte(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[3:0], a[7:4]};
  endfunction

  function automatic logic [63:0] mword(input int s, input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < (s != 0 ? 8 : 4); i++) v[8*i +: 8] = mbyte(a + 64'(i));
    return v;
  endfunction

  task automatic put32(input logic [63:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 64'(i)] = w[8*i +: 8];
  endtask

  task automatic put64(input logic [63:0] a, input logic [63:0] w);
    for (int i = 0; i < 8; i++) mem[a + 64'(i)] = w[8*i +: 8];
  endtask

  // Reference load: gather the bytes, extend, and list the aligned reads.
  function automatic void ref_load(
    input  int          s,
    input  logic [63:0] a,
    input  logic [2:0]  f3,
    output logic [63:0] d,
    output bit          e,
    output int          nrd,
    output logic [63:0] ra0,
    output logic [63:0] ra1
  );
    int nb, sz;
    bit ok, sgn;
    logic [63:0] mask, v;
    nb   = (s != 0) ? 8 : 4;
    mask = (s != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    sgn  = (f3[2] == 1'b0);
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2, 3'd6: sz = 4;
      default:    sz = 8;
    endcase
    ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
         ((s != 0) && (f3 inside {3'd3, 3'd6}));
    d = '0; e = 1'b0; nrd = 0; ra0 = '0; ra1 = '0;
    if (!ok || (!SPLIT && (a % 64'(sz)) != 0)) begin
      e = 1'b1;
      return;
    end
    v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = mbyte((a + 64'(i)) & mask);
    if (sgn && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
    d   = v & mask;
    ra0 = a - (a % 64'(nb));
    ra1 = (ra0 + 64'(nb)) & mask;
    nrd = ((a % 64'(nb)) + 64'(sz) > 64'(nb)) ? 2 : 1;
  endfunction

  // Memory responder: acks after ack_dly waiting cycles, logs read addresses.
  int          ack_dly   [2];
  int          wcnt      [2];
  bit          saw_req   [2];
  bit          held      [2];
  logic [63:0] held_addr [2];
  logic [63:0] rd_q0 [$];
  logic [63:0] rd_q1 [$];

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      mem_ack[s] = 1'b0;
      if (g_mreq(s) === 1'b1) begin
        saw_req[s] = 1'b1;
        if (held[s]) begin
          total++;
          if (g_maddr(s) !== held_addr[s]) begin
            bad++;
            $display("FAIL addr_hold[%0d] got=%h want=%h", s, g_maddr(s), held_addr[s]);
          end
        end
        if (wcnt[s] >= ack_dly[s]) begin
          mem_ack[s]   = 1'b1;
          mem_rdata[s] = mword(s, g_maddr(s));
          if (s != 0) rd_q1.push_back(g_maddr(s));
          else rd_q0.push_back(g_maddr(s));
          wcnt[s] = 0;
          held[s] = 1'b0;
        end else begin
          wcnt[s]++;
          held[s]      = 1'b1;
          held_addr[s] = g_maddr(s);
        end
      end else begin
        wcnt[s] = 0;
        held[s] = 1'b0;
      end
    end
  end

  task automatic do_load(
    input  int          s,
    input  logic [63:0] a,
    input  logic [2:0]  f3,
    input  logic [4:0]  tag,
    input  int          ackd,
    input  int          rspd,
    input  string       nm,
    output logic [63:0] gd,
    output bit          ge
  );
    logic [63:0] ed, ra0, ra1, d0;
    logic [63:0] rq [$];
    bit ee, rdy_seen, stable;
    int nrd, cyc, lat;
    logic e0;
    logic [4:0] t0;
    ref_load(s, a, f3, ed, ee, nrd, ra0, ra1);
    gd = '0;
    ge = 1'b0;
    ack_dly[s] = ackd;
    if (s != 0) rd_q1.delete();
    else rd_q0.delete();
    @(negedge clk);
    saw_req[s] = 1'b0;
    total++;
    if (g_rdy(s) !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_idle got=%b want=1", nm, g_rdy(s));
    end
    req_valid[s] = 1'b1;
    req_addr[s]  = a;
    req_f3[s]    = f3;
    req_tag[s]   = tag;
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    cyc = 0;
    rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (g_rdy(s) !== 1'b0) rdy_seen = 1'b1;
    end while (g_rv(s) !== 1'b1 && cyc < 100);
    total++;
    if (g_rv(s) !== 1'b1) begin
      bad++;
      $display("FAIL %s rsp_timeout got=%b want=1", nm, g_rv(s));
      return;
    end
    lat = ee ? 1 : 1 + nrd * (ackd + 1);
    total++;
    if (cyc !== lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", nm, cyc, lat);
    end
    d0 = g_rdata(s);
    e0 = g_err(s);
    t0 = g_tag(s);
    stable = 1'b1;
    for (int i = 0; i < rspd; i++) begin
      @(negedge clk);
      if (g_rv(s) !== 1'b1 || g_rdata(s) !== d0 || g_err(s) !== e0 ||
          g_tag(s) !== t0 || g_rdy(s) !== 1'b0) stable = 1'b0;
    end
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[s] = 1'b0;
    @(negedge clk);
    total++;
    if (g_rv(s) !== 1'b0 || g_rdy(s) !== 1'b1) begin
      bad++;
      $display("FAIL %s after_hs got=v%b r%b want=v0 r1", nm, g_rv(s), g_rdy(s));
    end
    total++;
    if (d0 !== ed) begin
      bad++;
      $display("FAIL %s data got=%h want=%h", nm, d0, ed);
    end
    total++;
    if (e0 !== ee) begin
      bad++;
      $display("FAIL %s err got=%b want=%b", nm, e0, ee);
    end
    total++;
    if (t0 !== tag) begin
      bad++;
      $display("FAIL %s tag got=%h want=%h", nm, t0, tag);
    end
    total++;
    if (!stable || rdy_seen) begin
      bad++;
      $display("FAIL %s hold got=stable%b rdy_seen%b want=stable1 rdy_seen0", nm, stable, rdy_seen);
    end
    total++;
    if (saw_req[s] !== (nrd > 0)) begin
      bad++;
      $display("FAIL %s mem_req_seen got=%b want=%b", nm, saw_req[s], nrd > 0);
    end
    rq = (s != 0) ? rd_q1 : rd_q0;
    total++;
    if (rq.size() !== nrd) begin
      bad++;
      $display("FAIL %s nreads got=%0d want=%0d", nm, rq.size(), nrd);
    end else begin
      for (int i = 0; i < nrd; i++) begin
        total++;
        if (rq[i] !== (i == 0 ? ra0 : ra1)) begin
          bad++;
          $display("FAIL %s read%0d got=%h want=%h", nm, i, rq[i], i == 0 ? ra0 : ra1);
        end
      end
    end
    gd = d0;
    ge = e0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++;
      if (g_rdy(s) !== 1'b1 || g_mreq(s) !== 1'b0 || g_rv(s) !== 1'b0 ||
          g_err(s) !== 1'b0) begin
        bad++;
        $display("FAIL reset_ctl[%0d] got=r%b m%b v%b e%b want=r1 m0 v0 e0",
                 s, g_rdy(s), g_mreq(s), g_rv(s), g_err(s));
      end
      total++;
      if (g_maddr(s) !== 64'd0 || g_rdata(s) !== 64'd0 || g_tag(s) !== 5'd0) begin
        bad++;
        $display("FAIL reset_data[%0d] got=a%h d%h t%h want=0",
                 s, g_maddr(s), g_rdata(s), g_tag(s));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [63:0] d;
    bit e;
    put32(64'h100, 32'h80FF_1234);
    do_load(0, 64'h103, 3'b000, 5'd3, 0, 0, "t1_lb", d, e);
    total++;
    if (d !== 64'hFFFF_FF80 || e !== 1'b0) begin
      bad++;
      $display("FAIL t1_const got=%h/%b want=ffffff80/0", d, e);
    end
    put32(64'h200, 32'hBEEF_0000);
    do_load(0, 64'h202, 3'b101, 5'h15, 1, 1, "t2_lhu", d, e);
    total++;
    if (d !== 64'h0000_BEEF || e !== 1'b0) begin
      bad++;
      $display("FAIL t2_const got=%h/%b want=0000beef/0", d, e);
    end
    put32(64'h0FC, 32'h1122_3344);
    put32(64'h100, 32'h5566_7788);
    do_load(0, 64'h0FE, 3'b010, 5'd9, 0, 0, "t3_lw_split", d, e);
    total++;
    if (d !== (SPLIT ? 64'h7788_1122 : 64'd0) || e !== !SPLIT) begin
      bad++;
      $display("FAIL t3_const got=%h/%b want=%h/%b", d, e,
               SPLIT ? 64'h7788_1122 : 64'd0, !SPLIT);
    end
    put64(64'h0, 64'h8000_0001_0000_0000);
    do_load(1, 64'h4, 3'b110, 5'd4, 0, 0, "t4_lwu", d, e);
    total++;
    if (d !== 64'h0000_0000_8000_0001 || e !== 1'b0) begin
      bad++;
      $display("FAIL t4_const got=%h/%b want=80000001/0", d, e);
    end
    do_load(1, 64'h4, 3'b111, 5'd5, 0, 0, "t4_illegal", d, e);
    total++;
    if (d !== 64'd0 || e !== 1'b1) begin
      bad++;
      $display("FAIL t4_illegal_const got=%h/%b want=0/1", d, e);
    end
    do_load(0, 64'h8, 3'b011, 5'd6, 0, 0, "ld_on_32", d, e);
    do_load(1, 64'h0, 3'b011, 5'd7, 0, 0, "ld_64", d, e);
    do_load(1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 5'd8, 1, 0, "wrap64", d, e);
    do_load(0, 64'hFFFF_FFFF, 3'b001, 5'd10, 0, 1, "wrap32", d, e);
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    bit e;
    do_load(0, 64'h300, 3'b010, 5'd11, 5, 3, "t5_bp32", d, e);
    do_load(1, 64'h305, 3'b001, 5'd12, 5, 3, "t5_bp64", d, e);
  endtask

  task automatic test_reset_midflight();
    logic [63:0] d;
    bit e;
    ack_dly[0] = 1000;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 64'h400;
    req_f3[0]    = 3'b010;
    req_tag[0]   = 5'd13;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    total++;
    if (mreq0 !== 1'b1 || maddr0 !== 32'h400) begin
      bad++;
      $display("FAIL t6_rd0 got=m%b a%h want=m1 a400", mreq0, maddr0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mreq0 !== 1'b0 || rv0 !== 1'b0 || rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL t6_abort got=m%b v%b r%b want=m0 v0 r1", mreq0, rv0, rdy0);
    end
    do_load(0, 64'h404, 3'b010, 5'd14, 0, 0, "t6_after", d, e);
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    bit e;
    for (int i = 0; i < 6; i++)
      do_load(i % 2, 64'h500 + 64'(i * 3), 3'(i % 6), 5'(i), 0, 0, "b2b", d, e);
  endtask

  task automatic test_random();
    logic [63:0] a, mask, base;
    logic [63:0] d;
    bit e;
    int s;
    for (int n = 0; n < 60; n++) begin
      s    = n % 2;
      mask = (s != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      a    = {32'($urandom), 32'($urandom)} & mask;
      if ($urandom_range(0, 3) == 0) a = mask - 64'($urandom_range(0, 7));
      base = a & ~64'h7;
      for (int i = 0; i < 16; i++) mem[(base + 64'(i)) & mask] = 8'($urandom);
      do_load(s, a, 3'($urandom_range(0, 7)), 5'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 2), "rand", d, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_addr[s]  = '0;
      req_f3[s]    = '0;
      req_tag[s]   = '0;
      mem_ack[s]   = 1'b0;
      mem_rdata[s] = '0;
      rsp_ready[s] = 1'b0;
      ack_dly[s]   = 0;
      wcnt[s]      = 0;
      saw_req[s]   = 1'b0;
      held[s]      = 1'b0;
      held_addr[s] = '0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
